// File: rtl/drop_pkg.sv
// -----------------------------------------------------------------------------
// drop_pkg
// Shared definitions for the bag drop timer controller:
//   - state_t       : controller state encoding
//   - DEF_*         : default parameter values used by the top and limit calc
//   - T_MAX         : saturation value for elapsed time and time limit
//   - sat16         : clamp a 24-bit intermediate to 16 bits
//   - inc_sat16     : 16-bit increment that sticks at T_MAX
// -----------------------------------------------------------------------------
package drop_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_TIMING  = 3'd2,
        ST_REQUEST = 3'd3,
        ST_DROP    = 3'd4,
        ST_REJECT  = 3'd5,
        ST_CLEAR   = 3'd6
    } state_t;

    localparam logic [15:0] DEF_BASE_LIM    = 16'd100;
    localparam logic [15:0] DEF_WEIGHT_STEP = 16'd4;
    localparam logic [7:0]  DEF_DROP_HOLD   = 8'd50;
    localparam logic [15:0] T_MAX           = 16'hFFFF;

    // Clamp a 24-bit sum into the 16-bit output range.
    function automatic logic [15:0] sat16(input logic [23:0] value);
        logic [15:0] result;
        if (value > {8'd0, T_MAX}) begin
            result = T_MAX;
        end else begin
            result = value[15:0];
        end
        return result;
    endfunction

    // Increment that holds at T_MAX instead of wrapping to zero.
    function automatic logic [15:0] inc_sat16(input logic [15:0] value);
        logic [15:0] result;
        if (value == T_MAX) begin
            result = T_MAX;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/drop_timer_ctrl_if.sv
// -----------------------------------------------------------------------------
// drop_timer_ctrl_if
// Signal bundle between the drop timer controller and its environment.
//   tick_en        : time-base strobe, one tick of elapsed time
//   bag_present    : belt sensor level
//   weight         : bag weight units, sampled while loading
//   confirm        : operator drop request
//   drop_activated : acceptance from the display/drop stage
//   t_act          : elapsed ticks since bag load
//   t_lim          : computed time limit for the current bag
//   drop_en        : drop request towards the display/drop stage
//   busy           : controller is handling a bag
//   done           : single-cycle pulse when an accepted drop completes
// Modports: slave = controller side, master = environment side.
// -----------------------------------------------------------------------------
interface drop_timer_ctrl_if;

    logic        tick_en;
    logic        bag_present;
    logic [7:0]  weight;
    logic        confirm;
    logic        drop_activated;
    logic [15:0] t_act;
    logic [15:0] t_lim;
    logic        drop_en;
    logic        busy;
    logic        done;

    modport slave (
        input  tick_en,
        input  bag_present,
        input  weight,
        input  confirm,
        input  drop_activated,
        output t_act,
        output t_lim,
        output drop_en,
        output busy,
        output done
    );

    modport master (
        output tick_en,
        output bag_present,
        output weight,
        output confirm,
        output drop_activated,
        input  t_act,
        input  t_lim,
        input  drop_en,
        input  busy,
        input  done
    );

endinterface

// File: rtl/drop_limit_calc.sv
// -----------------------------------------------------------------------------
// drop_limit_calc
// Combinational time-limit calculation: BASE_LIM + weight * WEIGHT_STEP,
// evaluated in 24 bits (large enough that 255 * 16'hFFFF + 16'hFFFF cannot
// overflow) and then saturated to 16'hFFFF.
// Ports:
//   weight_i : bag weight units
//   t_lim_o  : saturated time limit in ticks
// -----------------------------------------------------------------------------
module drop_limit_calc
    import drop_pkg::*;
#(
    parameter logic [15:0] BASE_LIM    = DEF_BASE_LIM,
    parameter logic [15:0] WEIGHT_STEP = DEF_WEIGHT_STEP
) (
    input  logic [7:0]  weight_i,
    output logic [15:0] t_lim_o
);

    logic [23:0] product_s;
    logic [23:0] sum_s;

    assign product_s = {16'd0, weight_i} * {8'd0, WEIGHT_STEP};
    assign sum_s     = product_s + {8'd0, BASE_LIM};
    assign t_lim_o   = sat16(sum_s);

endmodule

// File: rtl/drop_timer_ctrl.sv
// -----------------------------------------------------------------------------
// drop_timer_ctrl
// Bag drop timing controller. A new bag (rising edge of bag_present) loads a
// weight-dependent time limit, then elapsed ticks are counted until the
// operator confirms. The drop request is raised and the display/drop stage
// either accepts it (hold for DROP_HOLD ticks, then pulse done) or rejects it
// (request held until the bag is taken away).
// Ports:
//   clk : clock, all state on rising edge
//   rst : asynchronous active-high reset
//   bus : drop_timer_ctrl_if.slave (sensor, weight, confirm, acceptance in;
//         t_act, t_lim, drop_en, busy, done out; all outputs registered)
// -----------------------------------------------------------------------------
module drop_timer_ctrl
    import drop_pkg::*;
#(
    parameter logic [15:0] BASE_LIM    = DEF_BASE_LIM,
    parameter logic [15:0] WEIGHT_STEP = DEF_WEIGHT_STEP,
    parameter logic [7:0]  DROP_HOLD   = DEF_DROP_HOLD
) (
    input  logic                clk,
    input  logic                rst,
    drop_timer_ctrl_if.slave    bus
);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] t_act_q;
    logic [15:0] t_act_d;
    logic [15:0] t_lim_q;
    logic [15:0] t_lim_d;
    logic [7:0]  hold_q;
    logic [7:0]  hold_d;
    logic        drop_en_q;
    logic        drop_en_d;
    logic        busy_q;
    logic        busy_d;
    logic        done_q;
    logic        done_d;
    logic        bag_prev_q;
    logic        armed_q;
    logic        bag_rise_s;
    logic [15:0] lim_calc_s;

    drop_limit_calc #(
        .BASE_LIM    (BASE_LIM),
        .WEIGHT_STEP (WEIGHT_STEP)
    ) u_limit_calc (
        .weight_i (bus.weight),
        .t_lim_o  (lim_calc_s)
    );

    // A bag counts as new only once the sensor has been seen low since reset;
    // this keeps a bag left on the belt across a reset from being reloaded.
    assign bag_rise_s = armed_q & bus.bag_present & ~bag_prev_q;

    // Sensor history: previous level and the "seen low since reset" flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bag_prev_q <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            bag_prev_q <= bus.bag_present;
            armed_q    <= armed_q | ~bus.bag_present;
        end
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            t_act_q   <= 16'd0;
            t_lim_q   <= 16'd0;
            hold_q    <= 8'd0;
            drop_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            t_act_q   <= t_act_d;
            t_lim_q   <= t_lim_d;
            hold_q    <= hold_d;
            drop_en_q <= drop_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state, counters and next output values.
    always_comb begin
        state_d = state_q;
        t_act_d = t_act_q;
        t_lim_d = t_lim_q;
        hold_d  = 8'd0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                t_act_d = 16'd0;
                if (bag_rise_s) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_LOAD: begin
                t_lim_d = lim_calc_s;
                t_act_d = 16'd0;
                state_d = ST_TIMING;
            end

            ST_TIMING: begin
                // A tick in the confirm cycle still counts; freezing starts in REQUEST.
                if (bus.tick_en) begin
                    t_act_d = inc_sat16(t_act_q);
                end else begin
                    t_act_d = t_act_q;
                end
                // Bag removal wins over a simultaneous confirm.
                if (!bus.bag_present) begin
                    state_d = ST_IDLE;
                    t_act_d = 16'd0;
                end else if (bus.confirm) begin
                    state_d = ST_REQUEST;
                end else begin
                    state_d = ST_TIMING;
                end
            end

            ST_REQUEST: begin
                if (bus.drop_activated) begin
                    state_d = ST_DROP;
                end else begin
                    state_d = ST_REJECT;
                end
            end

            ST_DROP: begin
                // Bag removal is ignored here: an accepted drop always completes.
                if (bus.tick_en) begin
                    if (hold_q == (DROP_HOLD - 8'd1)) begin
                        state_d = ST_CLEAR;
                        done_d  = 1'b1;
                    end else begin
                        hold_d  = hold_q + 8'd1;
                    end
                end else begin
                    hold_d = hold_q;
                end
            end

            ST_REJECT: begin
                if (!bus.bag_present) begin
                    state_d = ST_IDLE;
                    t_act_d = 16'd0;
                end else begin
                    state_d = ST_REJECT;
                end
            end

            ST_CLEAR: begin
                if (!bus.bag_present) begin
                    state_d = ST_IDLE;
                    t_act_d = 16'd0;
                end else begin
                    state_d = ST_CLEAR;
                end
            end

            default: begin
                state_d = ST_IDLE;
                t_act_d = 16'd0;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        drop_en_d = (state_d == ST_REQUEST) || (state_d == ST_DROP) ||
                    (state_d == ST_REJECT);
        busy_d    = (state_d != ST_IDLE);
    end

    assign bus.t_act   = t_act_q;
    assign bus.t_lim   = t_lim_q;
    assign bus.drop_en = drop_en_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_drop_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_drop_timer_ctrl
// Directed scenarios plus randomized bag transactions for drop_timer_ctrl.
// Instance A uses default parameters; instance B uses WEIGHT_STEP=300 for the
// saturation scenario. The display/drop stage accepts a request when the
// elapsed time does not exceed the limit.
// -----------------------------------------------------------------------------
module tb_drop_timer_ctrl;

    localparam logic [15:0] BASE   = 16'd100;
    localparam logic [15:0] STEP   = 16'd4;
    localparam logic [15:0] STEP_B = 16'd300;
    localparam logic [7:0]  HOLD   = 8'd50;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    drop_timer_ctrl_if bus_a();
    drop_timer_ctrl_if bus_b();

    assign bus_a.drop_activated = bus_a.drop_en && (bus_a.t_act <= bus_a.t_lim);
    assign bus_b.drop_activated = bus_b.drop_en && (bus_b.t_act <= bus_b.t_lim);

    drop_timer_ctrl #(
        .BASE_LIM    (BASE),
        .WEIGHT_STEP (STEP),
        .DROP_HOLD   (HOLD)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    drop_timer_ctrl #(
        .BASE_LIM    (BASE),
        .WEIGHT_STEP (STEP_B),
        .DROP_HOLD   (HOLD)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // Reference: limit is base + weight*step, clamped to 65535.
    function automatic int exp_lim(input int w, input int step);
        int v;
        v = int'(BASE) + w * step;
        if (v > 65535) v = 65535;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issue n ticks on instance A with random idle gaps, no confirm.
    task automatic drive_ticks(input int n);
        int sent;
        sent = 0;
        bus_a.confirm = 1'b0;
        while (sent < n) begin
            bus_a.tick_en = ($urandom_range(0, 3) != 0);
            if (bus_a.tick_en) sent++;
            cyc();
        end
        bus_a.tick_en = 1'b0;
    endtask

    // Accepted-drop hold on instance A: done must pulse on exactly the
    // HOLD-th tick; the bag is pulled at tick drop_at (no effect expected).
    task automatic do_hold(input int drop_at, input int exp_tact);
        int   ticks;
        int   dones;
        logic t;
        ticks = 0;
        dones = 0;
        for (int c = 0; c < 2000 && ticks < int'(HOLD); c++) begin
            t = ($urandom_range(0, 3) != 0);
            bus_a.tick_en = t;
            if (t) ticks++;
            if (ticks == drop_at) bus_a.bag_present = 1'b0;
            cyc();
            if (bus_a.done) dones++;
            chk("hold_done", bus_a.done, (t && ticks == int'(HOLD)));
            chk("hold_drop_en", bus_a.drop_en, !(t && ticks == int'(HOLD)));
        end
        bus_a.tick_en = 1'b0;
        chk("hold_ticks_reached", ticks, HOLD);
        chk("clear_t_act", bus_a.t_act, exp_tact);
        cyc();
        chk("post_done_low", bus_a.done, 1'b0);
        chk("post_drop_en_low", bus_a.drop_en, 1'b0);
        chk("done_pulse_count", dones, 1);
    endtask

    initial begin
        bus_a.tick_en = 1'b0; bus_a.bag_present = 1'b0; bus_a.weight = 8'd0; bus_a.confirm = 1'b0;
        bus_b.tick_en = 1'b0; bus_b.bag_present = 1'b0; bus_b.weight = 8'd0; bus_b.confirm = 1'b0;

        // Reset state
        #1 rst = 1'b1;
        #2;
        chk("rst_t_act", bus_a.t_act, 16'd0);
        chk("rst_t_lim", bus_a.t_lim, 16'd0);
        chk("rst_drop_en", bus_a.drop_en, 1'b0);
        chk("rst_busy", bus_a.busy, 1'b0);
        chk("rst_done", bus_a.done, 1'b0);
        cyc(); cyc();
        rst = 1'b0;
        cyc(); cyc();
        chk("idle_busy", bus_a.busy, 1'b0);

        // Accepted drop: weight 10, 30 ticks
        bus_a.weight = 8'd10; bus_a.bag_present = 1'b1;
        cyc();
        chk("load_busy", bus_a.busy, 1'b1);
        cyc();
        chk("t1_t_lim", bus_a.t_lim, exp_lim(10, int'(STEP)));
        chk("t1_t_act0", bus_a.t_act, 16'd0);
        repeat (30) begin bus_a.tick_en = 1'b1; cyc(); end
        bus_a.tick_en = 1'b0;
        chk("t1_t_act30", bus_a.t_act, 16'd30);
        chk("t1_no_req", bus_a.drop_en, 1'b0);
        bus_a.confirm = 1'b1; cyc(); bus_a.confirm = 1'b0;
        chk("t1_req_drop_en", bus_a.drop_en, 1'b1);
        chk("t1_req_t_act", bus_a.t_act, 16'd30);
        cyc();
        chk("t1_drop_drop_en", bus_a.drop_en, 1'b1);
        do_hold(1000, 30);
        bus_a.bag_present = 1'b0; cyc();
        chk("t1_idle_busy", bus_a.busy, 1'b0);
        chk("t1_idle_t_act", bus_a.t_act, 16'd0);
        chk("t1_t_lim_held", bus_a.t_lim, exp_lim(10, int'(STEP)));

        // Rejected drop: weight 5, 130 ticks exceeds limit 120
        bus_a.weight = 8'd5; bus_a.bag_present = 1'b1;
        cyc(); cyc();
        chk("t2_t_lim", bus_a.t_lim, exp_lim(5, int'(STEP)));
        drive_ticks(130);
        chk("t2_t_act", bus_a.t_act, 16'd130);
        bus_a.confirm = 1'b1; cyc(); bus_a.confirm = 1'b0;
        chk("t2_req_drop_en", bus_a.drop_en, 1'b1);
        cyc();
        repeat (6) begin
            bus_a.confirm = 1'($urandom_range(0, 1));
            bus_a.tick_en = 1'($urandom_range(0, 1));
            cyc();
            chk("t2_rej_drop_en", bus_a.drop_en, 1'b1);
            chk("t2_rej_done", bus_a.done, 1'b0);
            chk("t2_rej_t_act", bus_a.t_act, 16'd130);
        end
        bus_a.confirm = 1'b0; bus_a.tick_en = 1'b0; bus_a.bag_present = 1'b0;
        cyc();
        chk("t2_idle_drop_en", bus_a.drop_en, 1'b0);
        chk("t2_idle_busy", bus_a.busy, 1'b0);

        // Abort wins over confirm in the same cycle
        bus_a.weight = 8'd0; bus_a.bag_present = 1'b1;
        cyc(); cyc();
        drive_ticks(5);
        bus_a.bag_present = 1'b0; bus_a.confirm = 1'b1;
        cyc();
        bus_a.confirm = 1'b0;
        chk("t3_abort_busy", bus_a.busy, 1'b0);
        chk("t3_abort_drop_en", bus_a.drop_en, 1'b0);
        cyc();
        chk("t3_abort_drop_en2", bus_a.drop_en, 1'b0);

        // Tick coincident with confirm, then reset during DROP
        bus_a.weight = 8'd20; bus_a.bag_present = 1'b1;
        cyc(); cyc();
        drive_ticks(9);
        chk("t4_t_act9", bus_a.t_act, 16'd9);
        bus_a.tick_en = 1'b1; bus_a.confirm = 1'b1;
        cyc();
        bus_a.confirm = 1'b0;
        chk("t4_t_act10", bus_a.t_act, 16'd10);
        chk("t4_req_drop_en", bus_a.drop_en, 1'b1);
        repeat (6) cyc();
        bus_a.tick_en = 1'b0;
        chk("t4_frozen", bus_a.t_act, 16'd10);
        chk("t4_drop_drop_en", bus_a.drop_en, 1'b1);
        rst = 1'b1;
        #1;
        chk("t4_async_t_act", bus_a.t_act, 16'd0);
        chk("t4_async_t_lim", bus_a.t_lim, 16'd0);
        chk("t4_async_drop_en", bus_a.drop_en, 1'b0);
        chk("t4_async_busy", bus_a.busy, 1'b0);
        cyc();
        rst = 1'b0;
        repeat (5) cyc();
        chk("t4_no_reload_busy", bus_a.busy, 1'b0);
        chk("t4_no_reload_t_lim", bus_a.t_lim, 16'd0);
        bus_a.bag_present = 1'b0; cyc();
        bus_a.bag_present = 1'b1; cyc();
        chk("t4_reload_busy", bus_a.busy, 1'b1);
        cyc();
        chk("t4_reload_t_lim", bus_a.t_lim, exp_lim(20, int'(STEP)));
        bus_a.bag_present = 1'b0; cyc();
        chk("t4_end_busy", bus_a.busy, 1'b0);

        // Saturation on instance B: weight 255 with step 300
        bus_b.weight = 8'd255; bus_b.bag_present = 1'b1;
        cyc(); cyc();
        chk("t5_t_lim_sat", bus_b.t_lim, exp_lim(255, int'(STEP_B)));
        bus_b.tick_en = 1'b1;
        repeat (65535) cyc();
        chk("t5_t_act_max", bus_b.t_act, 16'hFFFF);
        repeat (5) cyc();
        bus_b.tick_en = 1'b0;
        chk("t5_t_act_nowrap", bus_b.t_act, 16'hFFFF);
        bus_b.confirm = 1'b1; cyc(); bus_b.confirm = 1'b0;
        chk("t5_req_drop_en", bus_b.drop_en, 1'b1);
        cyc();
        bus_b.tick_en = 1'b1;
        repeat (int'(HOLD)) cyc();
        bus_b.tick_en = 1'b0;
        chk("t5_done", bus_b.done, 1'b1);
        cyc();
        chk("t5_done_low", bus_b.done, 1'b0);
        chk("t5_drop_en_low", bus_b.drop_en, 1'b0);
        bus_b.bag_present = 1'b0; cyc();
        chk("t5_idle_busy", bus_b.busy, 1'b0);

        // Randomized bag transactions on instance A
        for (int k = 0; k < 12; k++) begin
            int w, lim, n, coin, drop_at;
            bit acc;
            w   = int'($urandom_range(0, 63));
            lim = exp_lim(w, int'(STEP));
            if ((k % 4) == 3) n = int'($urandom_range(0, 20));
            else              n = int'($urandom_range(lim - 6, lim + 6));
            coin = (n > 0) ? int'($urandom_range(0, 1)) : 0;
            acc  = (n <= lim);
            bus_a.weight = 8'(w); bus_a.bag_present = 1'b1;
            cyc(); cyc();
            chk("rnd_t_lim", bus_a.t_lim, lim);
            chk("rnd_t_act0", bus_a.t_act, 16'd0);
            drive_ticks(n - coin);
            bus_a.confirm = 1'b1; bus_a.tick_en = 1'(coin);
            cyc();
            bus_a.confirm = 1'b0; bus_a.tick_en = 1'b0;
            chk("rnd_req_t_act", bus_a.t_act, n);
            chk("rnd_req_drop_en", bus_a.drop_en, 1'b1);
            cyc();
            chk("rnd_post_req_drop_en", bus_a.drop_en, 1'b1);
            chk("rnd_post_req_done", bus_a.done, 1'b0);
            if (acc) begin
                drop_at = int'($urandom_range(1, int'(HOLD) + 30));
                do_hold(drop_at, n);
            end else begin
                repeat (3) begin
                    bus_a.tick_en = 1'($urandom_range(0, 1));
                    bus_a.confirm = 1'($urandom_range(0, 1));
                    cyc();
                    chk("rnd_rej_drop_en", bus_a.drop_en, 1'b1);
                    chk("rnd_rej_done", bus_a.done, 1'b0);
                end
                bus_a.tick_en = 1'b0; bus_a.confirm = 1'b0;
            end
            bus_a.bag_present = 1'b0;
            cyc();
            chk("rnd_idle_busy", bus_a.busy, 1'b0);
            chk("rnd_idle_drop_en", bus_a.drop_en, 1'b0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/drop_timer_ctrl.md
DROP_TIMER_CTRL -- requirements
Module: drop_timer_ctrl

Interface
REQ-001 Parameter BASE_LIM, default 16'd100, base time limit in ticks.
REQ-002 Parameter WEIGHT_STEP, default 16'd4, ticks added per weight unit.
REQ-003 Parameter DROP_HOLD, default 8'd50, ticks drop_en is held after an accepted drop (1..255).
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 tick_en  input  1  single-cycle time-base strobe, one tick of t_act.
REQ-007 bag_present  input  1  belt sensor, synchronous to clk, level.
REQ-008 weight  input  8  bag weight units, sampled in LOAD only.
REQ-009 confirm  input  1  operator drop request, level or pulse, sampled in TIMING only.
REQ-010 drop_activated  input  1  acceptance from display/drop stage, combinationally derived from drop_en, t_act and t_lim.
REQ-011 t_act  output  16  elapsed ticks since bag load, registered.
REQ-012 t_lim  output  16  computed time limit, registered.
REQ-013 drop_en  output  1  drop request to display/drop stage, registered.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse on completed accepted drop.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, TIMING, REQUEST, DROP, REJECT, CLEAR.
REQ-017 IDLE: t_act=0, drop_en=0; bag_present rising edge (registered previous value 0, current 1) -> LOAD next cycle.
REQ-018 LOAD (one cycle): t_lim <= BASE_LIM + weight*WEIGHT_STEP computed in 24 bits, saturated to 16'hFFFF; t_act <= 0; -> TIMING.
REQ-019 TIMING: t_act increments by 1 on each tick_en, saturating at 16'hFFFF (no wrap).
REQ-020 TIMING: bag_present=0 -> IDLE (abort, no done); else confirm=1 -> REQUEST; abort has priority over confirm in the same cycle.
REQ-021 TIMING: tick_en coincident with confirm SHALL still count; t_act frozen from REQUEST onward.
REQ-022 REQUEST: drop_en=1; drop_activated sampled this cycle: 1 -> DROP, 0 -> REJECT.
REQ-023 DROP: drop_en=1; internal 8-bit hold counter counts tick_en; on DROP_HOLD-th tick -> CLEAR with done=1 that transition cycle.
REQ-024 REJECT: drop_en=1 held (limit-exceeded display); bag_present=0 -> IDLE; confirm ignored.
REQ-025 CLEAR: drop_en=0; bag_present=0 -> IDLE; otherwise wait (no re-trigger until bag removed and re-presented).
REQ-026 done SHALL never assert outside the DROP->CLEAR transition.
REQ-027 t_lim SHALL hold its value from LOAD until next LOAD; cleared only by reset.
REQ-028 bag_present falling in DROP SHALL NOT abort the hold; drop completes.

Reset
REQ-029 rst=1 SHALL asynchronously force state IDLE, t_act=0, t_lim=0, drop_en=0, busy=0, done=0, hold counter=0, bag_present history=0.
REQ-030 rst asserted mid-operation SHALL abandon the bag; after release a bag already present SHALL NOT trigger LOAD until bag_present falls and rises again.

Structure
REQ-031 State encoding typedef and default parameter constants SHALL live in shared package drop_pkg.
REQ-032 Limit computation SHALL be sub-module drop_limit_calc (combinational multiply-add-saturate); all else in one module.

Verification
REQ-033 weight=10, bag rise, 30 ticks, confirm -> t_lim=140, t_act=30, drop_en=1, drop_activated=1, after 50 ticks done pulse once, drop_en=0.
REQ-034 weight=5 (t_lim=120), 130 ticks, confirm -> REQUEST sees drop_activated=0 -> REJECT, drop_en stays 1 until bag_present=0, then IDLE, no done.
REQ-035 weight=255, WEIGHT_STEP=16'd300 -> t_lim=16'hFFFF saturated; t_act forced past 65535 ticks stays 16'hFFFF.
REQ-036 bag_present=0 and confirm=1 same cycle in TIMING -> IDLE, drop_en never asserts.
REQ-037 rst pulse during DROP with bag_present held 1 -> outputs zero immediately; no LOAD until bag falls and rises.
REQ-038 tick_en and confirm same cycle at t_act=9 -> REQUEST with t_act=10, then frozen.
